digit_scan_ctrl: RTL and testbench
==================================

# digit_scan_ctrl

Time-multiplexed digit scan controller for the 4-digit seven-segment display path. It drives the 2-bit select `S` of the 4:1 16-bit word multiplexer, so the mux always presents the word for the active digit. It also generates the matching active-low anode enables, with a dead-time gap between slots to suppress ghosting. Per-digit blanking and a run/hold enable let upstream logic suppress leading zeros or freeze the scan.

## Interface
Parameters:
- `PRESCALE`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `DEAD`, default 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ DEAD < PRESCALE.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: 1 = scan runs; 0 = scan holds and the display goes dark.
- `blank_mask`, input, 4: bit i = 1 forces digit i dark for its whole slot.
- `S`, output, 2: digit select to the word mux (0..3).
- `AN`, output, 4: anode enables, active-low, one-hot-low or all-high.
- `tick`, output, 1: one-cycle pulse in the first cycle of every new slot.

## Operation
Prescale counter:
- `cnt` has width $clog2(PRESCALE).
- While `en` = 1, it counts 0..PRESCALE-1.
- At PRESCALE-1 it wraps to 0, and on the same edge `S` ← S+1 mod 4 (3 wraps to 0).

Scan phase, derived from `cnt` and `en`:
- HOLD: `en` = 0. `cnt` and `S` freeze and `AN` = 4'hF.
  - When `en` returns to 1, counting resumes from the frozen `cnt`; the slot is neither restarted nor skipped.
- DEAD: `en` = 1 and cnt < DEAD. `AN` = 4'hF.
- ON: `en` = 1 and cnt ≥ DEAD.
  - `AN` = ~(4'b0001 << S) if blank_mask[S] = 0.
  - `AN` = 4'hF if blank_mask[S] = 1.

Slot boundary:
- `tick` = 1 in exactly the cycle where `cnt` = 0 following a wrap.
- `tick` is not asserted after reset release and not while in HOLD.

Enable and mask sampling:
- `blank_mask` and `en` are sampled every cycle.
- A change affects `AN` on the next clock edge; there is no slot-boundary latching.

Reset (asynchronous, effective immediately):
- Reset values: cnt = 0, `S` = 0, `AN` = 4'hF, `tick` = 0.
- Reset mid-slot abandons the slot.
- The first slot after release is digit 0, starting with its DEAD phase.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `AN` is computed from next-state `cnt`/`S`, so `AN`, `S` and `tick` change on the same edge and are always mutually consistent.
- Select setup: `S` changes at the start of a slot while `AN` is still 4'hF for DEAD cycles, so mux output settles before any anode turns on.
- With DEAD = 0, `AN` switches directly from one digit to the next on the wrap edge.
- Slot period is exactly PRESCALE cycles; full frame is 4·PRESCALE cycles, excluding HOLD time.
- Simultaneous `en` fall and wrap: `en` = 0 wins. No wrap, `S` is held, no `tick`.

## Structure
Shared package `disp_pkg`:
- `DIGITS` = 4
- `SEL_W` = 2
- `AN_OFF` = 4'hF
- `AN_W` = 4

These are also used by the mux and segment decoder.

Sub-module `scan_prescaler`:
- Parameterised modulo-PRESCALE counter.
- Inputs: `clk`, `rst_n`, `en`.
- Outputs: `cnt` and `wrap` (combinational, cnt == PRESCALE-1 && en).
- The top level holds the `S`, `AN` and `tick` registers and the phase logic.

## Test plan
Bench parameters: PRESCALE = 8, DEAD = 2.
- **Reset:** hold `rst_n` = 0, `en` = 1 → `S` = 0, `AN` = 4'hF, `tick` = 0. Release → `AN` = 4'hF for 2 cycles, then 4'b1110 for 6 cycles.
- **Free run:** `en` = 1, blank_mask = 0 for 32 cycles → `S` sequence 0,1,2,3. `AN` walks 1110, 1101, 1011, 0111, each preceded by 2 cycles of 4'hF. `tick` pulses at cycles 8, 16, 24.
- **Blanking:** blank_mask = 4'b0010 → `AN` = 4'hF for the entire S = 1 slot. The other digits are unaffected and `tick` still pulses.
- **Hold:** drop `en` at cnt = 5 of S = 2 for 10 cycles → `AN` = 4'hF next cycle and `S` stays 2. On re-enable, `AN` = 4'b1011 resumes for 2 more cycles, then wraps to S = 3.
- **Collision:** drop `en` in the same cycle as cnt = 7 → no `tick`, `S` is unchanged, `AN` = 4'hF.
- **Mid-run reset:** assert `rst_n` = 0 asynchronously mid-slot at S = 3 → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display constants and helpers for the scan controller, word mux and segment decoder.
// No logic or registers; no flow control.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int SEL_W  = 2;
    localparam int AN_W   = 4;
    localparam logic [AN_W-1:0] AN_OFF = 4'hF;

    typedef enum logic [1:0] {
        PH_HOLD,
        PH_DEAD,
        PH_ON
    } phase_e;

    // Active-low one-hot anode pattern for a selected digit.
    function automatic logic [AN_W-1:0] an_onehot_low(input logic [SEL_W-1:0] sel);
        return ~(AN_W'(1) << sel);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-PRESCALE slot counter; wrap is combinational and only asserts while enabled.
// Latency: cnt registered, wrap same cycle as cnt == PRESCALE-1; en = 0 freezes the count.
module scan_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit display scan: digit select, active-low anodes with dead time, slot tick.
// Latency: all outputs registered from next-state cnt/S; en = 0 holds the scan and blanks the display.
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [AN_W-1:0]  blank_mask,
    output logic [SEL_W-1:0] S,
    output logic [AN_W-1:0]  AN,
    output logic             tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic [SEL_W-1:0] s_nxt;
    phase_e           phase_nxt;
    logic [AN_W-1:0]  an_nxt;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Anodes are decoded from the state the counter is about to enter, so
    // S, AN and tick all move together on one edge.
    always_comb begin
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        s_nxt = wrap ? S + SEL_W'(1) : S;

        if (!en) begin
            phase_nxt = PH_HOLD;
        end else if (cnt_nxt < DEAD_C) begin
            phase_nxt = PH_DEAD;
        end else begin
            phase_nxt = PH_ON;
        end

        an_nxt = AN_OFF;
        if (phase_nxt == PH_ON && !blank_mask[s_nxt]) begin
            an_nxt = an_onehot_low(s_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            AN   <= AN_OFF;
            tick <= 1'b0;
        end else begin
            S    <= s_nxt;
            AN   <= an_nxt;
            tick <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

    localparam int PRESCALE = 8;
    localparam int DEAD     = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] blank_mask;
    logic [1:0] S;
    logic [3:0] AN;
    logic       tick;

    int n_checks = 0;
    int n_errors = 0;

    digit_scan_ctrl #(
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .blank_mask (blank_mask),
        .S          (S),
        .AN         (AN),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Behavioural model: slot position and digit as plain integers.
    int         m_pos;
    int         m_dig;
    bit         m_tick;
    bit         m_en_q;
    logic [3:0] m_mask_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos    = 0;
            m_dig    = 0;
            m_tick   = 0;
            m_en_q   = 0;
            m_mask_q = '0;
        end else begin
            m_tick = 0;
            if (en) begin
                m_pos = m_pos + 1;
                if (m_pos == PRESCALE) begin
                    m_pos  = 0;
                    m_dig  = (m_dig + 1) % 4;
                    m_tick = 1;
                end
            end
            m_en_q   = en;
            m_mask_q = blank_mask;
        end
    end

    function automatic logic [3:0] model_an();
        if (!m_en_q || m_pos < DEAD || m_mask_q[m_dig])
            return 4'hF;
        return 4'hF ^ (4'b0001 << m_dig);
    endfunction

    int cyc;

    always @(negedge clk) begin
        chk("model_S",    cyc, {2'b00, S},    4'(m_dig));
        chk("model_AN",   cyc, AN,            model_an());
        chk("model_tick", cyc, {3'b000, tick}, {3'b000, m_tick});
    end

    // Hand-computed expectations, keyed by cycle count since reset release.
    typedef struct {
        int         k;
        logic [1:0] s;
        logic [3:0] an;
        logic       t;
    } lit_t;
    lit_t tbl[$];

    task automatic add(input int k, input logic [1:0] s, input logic [3:0] an, input logic t);
        lit_t e;
        e.k = k; e.s = s; e.an = an; e.t = t;
        tbl.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        foreach (tbl[i]) begin
            if (tbl[i].k == cyc) begin
                chk("lit_S",    cyc, {2'b00, S},     {2'b00, tbl[i].s});
                chk("lit_AN",   cyc, AN,             tbl[i].an);
                chk("lit_tick", cyc, {3'b000, tick}, {3'b000, tbl[i].t});
            end
        end
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc <= n) step();
    endtask

    initial begin
        // free run after release
        add(0, 2'd0, 4'hF, 0);   add(1, 2'd0, 4'hF, 0);
        add(2, 2'd0, 4'b1110, 0); add(7, 2'd0, 4'b1110, 0);
        add(8, 2'd1, 4'hF, 1);   add(9, 2'd1, 4'hF, 0);
        add(10, 2'd1, 4'b1101, 0); add(16, 2'd2, 4'hF, 1);
        add(18, 2'd2, 4'b1011, 0); add(24, 2'd3, 4'hF, 1);
        add(26, 2'd3, 4'b0111, 0); add(31, 2'd3, 4'b0111, 0);
        // blanking of digit 1
        add(32, 2'd0, 4'hF, 1);  add(34, 2'd0, 4'b1110, 0);
        add(40, 2'd1, 4'hF, 1);  add(42, 2'd1, 4'hF, 0);
        add(47, 2'd1, 4'hF, 0);  add(48, 2'd2, 4'hF, 1);
        add(50, 2'd2, 4'b1011, 0);
        // hold in the middle of digit 2
        add(85, 2'd2, 4'b1011, 0); add(86, 2'd2, 4'hF, 0);
        add(95, 2'd2, 4'hF, 0);  add(96, 2'd2, 4'b1011, 0);
        add(97, 2'd2, 4'b1011, 0); add(98, 2'd3, 4'hF, 1);
        // en falls on the wrap cycle
        add(105, 2'd3, 4'b0111, 0); add(106, 2'd3, 4'hF, 0);
        add(108, 2'd3, 4'hF, 0); add(109, 2'd0, 4'hF, 1);
        add(136, 2'd3, 4'b0111, 0);
        // after the mid-run reset
        add(200, 2'd0, 4'hF, 0); add(201, 2'd0, 4'hF, 0);
        add(202, 2'd0, 4'b1110, 0); add(208, 2'd1, 4'hF, 1);

        cyc        = -1;
        rst_n      = 1'b0;
        en         = 1'b1;
        blank_mask = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_S",    -1, {2'b00, S},     4'h0);
        chk("reset_AN",   -1, AN,             4'hF);
        chk("reset_tick", -1, {3'b000, tick}, 4'h0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;

        run_until(31);
        blank_mask = 4'b0010;
        run_until(63);
        blank_mask = 4'b0000;
        run_until(85);
        en = 1'b0;
        run_until(95);
        en = 1'b1;
        run_until(105);
        en = 1'b0;
        run_until(108);
        en = 1'b1;
        run_until(136);

        // asynchronous reset lands between clock edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_S",    137, {2'b00, S},     4'h0);
        chk("async_rst_AN",   137, AN,             4'hF);
        chk("async_rst_tick", 137, {3'b000, tick}, 4'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 200;
        run_until(215);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
